snake_tile_renderer: RTL and testbench
======================================

# snake_tile_renderer

Command-consumer end of the snake drawing interface. Accepts 32-bit tile commands on `cmd`/`cmd_vld` (point writes and rectangle fills) from the game core. It buffers them in a small FIFO and executes them one tile per clock into an internal tile-colour memory of size H_LOGIC_MAX+1 by V_LOGIC_MAX+1. A synchronous read port lets the VGA pixel pipeline fetch the colour ID of any logical tile.

## Interface
- `H_LOGIC_WIDTH`, 5, tile x-coordinate width
- `V_LOGIC_WIDTH`, 5, tile y-coordinate width
- `H_LOGIC_MAX`, 5'd31, last valid tile column
- `V_LOGIC_MAX`, 5'd23, last valid tile row
- `COLOR_ID_WIDTH`, 8, colour ID width
- `FIFO_DEPTH`, 4, command FIFO entries (power of two)
- `CMD_WIDTH` (localparam), 4 + 2·(H+V) + COLOR = 32
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd`  in  32  command word
- `cmd_vld`  in  1  `cmd` valid this cycle; no backpressure
- `rd_x`  in  5  read tile column
- `rd_y`  in  5  read tile row
- `rd_color`  out  8  colour of (`rd_x`,`rd_y`), registered
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `ovf`  out  1  sticky: a command was dropped since reset

## Operation
- Decode: `op` = cmd[31:28].
  - op 0, point: x=[27:23], y=[22:18], color=[17:10]; bits [9:0] are ignored.
  - op 1, rect: x0=[27:23], y0=[22:18], x1=[17:13], y1=[12:8], color=[7:0].
  - Other ops: consumed, no write.
- FIFO:
  - Push on every `cmd_vld` cycle unless full.
  - A push while full is dropped and sets `ovf`.
  - Full is evaluated before the same-cycle pop.
  - Push and pop in the same cycle are allowed when not full.
- Memory:
  - Address is {y, x}, 2^(H+V) words × COLOR_ID_WIDTH.
  - One write port (FSM) and one read port (`rd_x`/`rd_y`).
  - Contents are not reset: undefined at power-up and retained across `rst`.
- FSM states IDLE, DISPATCH, FILL:
  - IDLE: if FIFO non-empty, pop into a command register, go to DISPATCH. Otherwise stay.
  - DISPATCH, op 0: write color at (x,y) only if x≤H_LOGIC_MAX and y≤V_LOGIC_MAX, then go to IDLE.
  - DISPATCH, op 1: clamp x1 to H_LOGIC_MAX and y1 to V_LOGIC_MAX. If x0>x1, y0>y1, x0>H_LOGIC_MAX or y0>V_LOGIC_MAX, go to IDLE with no writes. Otherwise load cx=x0, cy=y0 and go to FILL.
  - DISPATCH, other op: go to IDLE.
  - FILL: write color at (cx,cy) each cycle. If cx==x1, set cx=x0 and cy=cy+1; else cx=cx+1. After writing (x1,y1), go to IDLE.
- Row-major scan order. No write outside the clamped bounds; counters never wrap past MAX.
- Back-to-back: IDLE may pop on the cycle after DISPATCH or the last FILL write.
- `rst` mid-operation:
  - FSM goes to IDLE and the FIFO empties; `ovf`=0.
  - Tiles already written stay written; the rest of the fill is abandoned.

## Timing
- Reset values: `rd_color`=0, `busy`=0, `ovf`=0.
- Point command pushed into an empty FIFO on cycle N: popped N+1, written N+2.
- A read of that tile issued on N+3 shows the new value on `rd_color` at N+4.
- Rect of W×H tiles: 2 + W·H cycles, from the pop cycle to the last write inclusive; empty rect takes 2 cycles.
- Sustained point throughput: one command per 2 cycles.
- `rd_color` latency is 1 cycle. Same-cycle read and write of one address returns the old data.
- `busy` is registered from state and FIFO count. It goes low the cycle after the final write when the FIFO is empty.
- `ovf` sets the cycle after the dropped push.

## Test plan
- Reset, push rect {1,0,0,31,23,00}, then point {0,x=3,y=5,0x0f} → (3,5) reads 0x0f, (4,5) reads 0x00, `ovf`=0.
- Full-screen rect colour 0xff → `busy` high for 770 cycles after pop. All 768 tiles read 0xff; addresses with y 24–31 are not written.
- Pushes on consecutive cycles:
  - Sequence: point (1,1)=0x0f, point (2,1)=0xff, point (3,1)=0xe0, then rect (0,0)-(1,0)=0x11.
  - Expected: all executed in order, final values match, `ovf`=0, `busy` falls after the last write.
- Overflow:
  - Sequence: push a full-screen rect, then push 6 point commands on the next 6 cycles.
  - Expected: the first 4 are kept and executed after the fill, points 5–6 are dropped, `ovf`=1 until `rst`.
- Boundaries:
  - Rect x0=10, x1=5 → no writes, IDLE after 2 cycles.
  - Point y=30 → ignored.
  - Rect (0,20)-(0,30) → writes rows 20–23 only.
  - Op 0xF → no write.
- Assert `rst` for 1 cycle midway through a full-screen fill (cycle 300) → `busy`=0 and `ovf`=0 immediately. Tiles written before reset keep the new colour, later ones keep the old; the next point command executes normally.

Source files
------------

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: buffers point/rect tile commands in a small FIFO and
// paints them one tile per clock into a tile-colour memory with a sync read port.
module snake_tile_renderer #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = 5'd23,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CMD_WIDTH = 4 + 2 * (H_LOGIC_WIDTH + V_LOGIC_WIDTH) + COLOR_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CMD_WIDTH-1:0]      cmd,
  input  logic                      cmd_vld,
  input  logic [H_LOGIC_WIDTH-1:0]  rd_x,
  input  logic [V_LOGIC_WIDTH-1:0]  rd_y,
  output logic [COLOR_ID_WIDTH-1:0] rd_color,
  output logic                      busy,
  output logic                      ovf
);

  localparam int HW     = H_LOGIC_WIDTH;
  localparam int VW     = V_LOGIC_WIDTH;
  localparam int CW     = COLOR_ID_WIDTH;
  localparam int AW     = HW + VW;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Field positions inside a command word, packed from the MSB down.
  localparam int OP_LSB = CMD_WIDTH - 4;
  localparam int X0_LSB = OP_LSB - HW;
  localparam int Y0_LSB = X0_LSB - VW;
  localparam int PC_LSB = Y0_LSB - CW;   // point colour
  localparam int X1_LSB = Y0_LSB - HW;
  localparam int Y1_LSB = X1_LSB - VW;

  localparam logic [3:0] OP_POINT = 4'd0;
  localparam logic [3:0] OP_RECT  = 4'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    FILL     = 2'd2
  } state_t;

  // Command FIFO
  logic [CMD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // FSM and fill context
  state_t               state;
  logic [CMD_WIDTH-1:0] cmd_r;
  logic [HW-1:0]        cx;
  logic [VW-1:0]        cy;
  logic [HW-1:0]        fx0;
  logic [HW-1:0]        fx1;
  logic [VW-1:0]        fy1;
  logic [CW-1:0]        fcolor;

  // Decoded fields of the held command
  logic [3:0]           op;
  logic [HW-1:0]        px;
  logic [VW-1:0]        py;
  logic [CW-1:0]        pcolor;
  logic [HW-1:0]        x1_raw;
  logic [VW-1:0]        y1_raw;
  logic [CW-1:0]        rcolor;
  logic [HW-1:0]        x1c;
  logic [VW-1:0]        y1c;
  logic                 point_ok;
  logic                 rect_ok;
  logic                 fill_last;

  // Tile memory write port
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [CW-1:0]        wdata;
  logic [CW-1:0]        tile_mem [2**AW];

  // Fullness is judged on the current count, before any same-cycle pop.
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == {CNT_W{1'b0}});
  assign push  = cmd_vld & ~full;
  assign pop   = (state == IDLE) & ~empty;

  assign op     = cmd_r[OP_LSB +: 4];
  assign px     = cmd_r[X0_LSB +: HW];
  assign py     = cmd_r[Y0_LSB +: VW];
  assign pcolor = cmd_r[PC_LSB +: CW];
  assign x1_raw = cmd_r[X1_LSB +: HW];
  assign y1_raw = cmd_r[Y1_LSB +: VW];
  assign rcolor = cmd_r[CW-1:0];

  assign x1c       = (x1_raw > H_LOGIC_MAX) ? H_LOGIC_MAX : x1_raw;
  assign y1c       = (y1_raw > V_LOGIC_MAX) ? V_LOGIC_MAX : y1_raw;
  assign point_ok  = (px <= H_LOGIC_MAX) && (py <= V_LOGIC_MAX);
  assign rect_ok   = (px <= x1c) && (py <= y1c) && (px <= H_LOGIC_MAX) && (py <= V_LOGIC_MAX);
  assign fill_last = (cx == fx1) && (cy == fy1);

  // Next FIFO occupancy, shared by the FIFO counter and the busy flag.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // FIFO storage; contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cmd;
    end
  end

  // Sticky overflow: a valid command arrived while the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (cmd_vld && full) begin
      ovf <= 1'b1;
    end
  end

  // Command FSM: pop, decode, then scan a rectangle row-major; busy tracks next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cmd_r  <= {CMD_WIDTH{1'b0}};
      cx     <= {HW{1'b0}};
      cy     <= {VW{1'b0}};
      fx0    <= {HW{1'b0}};
      fx1    <= {HW{1'b0}};
      fy1    <= {VW{1'b0}};
      fcolor <= {CW{1'b0}};
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            cmd_r <= fifo_mem[rd_ptr];
            state <= DISPATCH;
            busy  <= 1'b1;
          end else begin
            busy  <= (count_nxt != {CNT_W{1'b0}});
          end
        end
        DISPATCH: begin
          if ((op == OP_RECT) && rect_ok) begin
            cx     <= px;
            cy     <= py;
            fx0    <= px;
            fx1    <= x1c;
            fy1    <= y1c;
            fcolor <= rcolor;
            state  <= FILL;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            busy   <= (count_nxt != {CNT_W{1'b0}});
          end
        end
        FILL: begin
          if (fill_last) begin
            state <= IDLE;
            busy  <= (count_nxt != {CNT_W{1'b0}});
          end else begin
            busy  <= 1'b1;
            if (cx == fx1) begin
              cx <= fx0;
              cy <= cy + VW'(1);
            end else begin
              cx <= cx + HW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write port select: point writes in DISPATCH, rectangle tiles in FILL.
  always_comb begin
    we    = 1'b0;
    waddr = {AW{1'b0}};
    wdata = {CW{1'b0}};
    if ((state == DISPATCH) && (op == OP_POINT) && point_ok) begin
      we    = 1'b1;
      waddr = {py, px};
      wdata = pcolor;
    end else if (state == FILL) begin
      we    = 1'b1;
      waddr = {cy, cx};
      wdata = fcolor;
    end else begin
      we    = 1'b0;
    end
  end

  // Tile memory write; deliberately not reset so the picture survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      tile_mem[waddr] <= wdata;
    end
  end

  // Registered read port; a same-cycle write to the address returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_color <= {CW{1'b0}};
    end else begin
      rd_color <= tile_mem[{rd_y, rd_x}];
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Testbench for snake_tile_renderer: directed scenarios plus random command
// streams, checked against a command-level model of the picture and timing.
module tb_snake_tile_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = 32'd0;
  logic        cmd_vld = 1'b0;
  logic [4:0]  rd_x = 5'd0;
  logic [4:0]  rd_y = 5'd0;
  logic [7:0]  rd_color;
  logic        busy;
  logic        ovf;

  always #5 clk = ~clk;

  snake_tile_renderer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_color (rd_color),
    .busy     (busy),
    .ovf      (ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mm [0:23][0:31];   // expected colour of every visible tile
  int         cyc = 0;           // cycle index, advanced right after each rising edge
  int         pend_pop[$];       // predicted pop cycle of each command still queued
  int         last_free = 0;     // first cycle the executor is free again
  bit         drop_seen = 1'b0;
  bit         last_busy = 1'b0;
  bit         acc_dummy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_point(input logic [4:0] x, input logic [4:0] y, input logic [7:0] c);
    return {4'd0, x, y, c, 10'd0};
  endfunction

  function automatic logic [31:0] mk_rect(input logic [4:0] x0, input logic [4:0] y0,
                                          input logic [4:0] x1, input logic [4:0] y1,
                                          input logic [7:0] c);
    return {4'd1, x0, y0, x1, y1, c};
  endfunction

  // Cycles the executor spends on a command, counted from its pop.
  function automatic int cmd_dur(input logic [31:0] c);
    int x0, y0, x1, y1;
    x0 = int'(c[27:23]); y0 = int'(c[22:18]);
    x1 = int'(c[17:13]); y1 = int'(c[12:8]);
    if (x1 > 31) x1 = 31;
    if (y1 > 23) y1 = 23;
    if (c[31:28] == 4'd1 && x0 <= x1 && y0 <= y1 && y0 <= 23)
      return 2 + (x1 - x0 + 1) * (y1 - y0 + 1);
    return 2;
  endfunction

  // Paint a command into the model; limit < 0 paints it all, else the first limit tiles.
  task automatic model_apply(input logic [31:0] c, input int limit);
    int x0, y0, x1, y1, n;
    x0 = int'(c[27:23]); y0 = int'(c[22:18]);
    n = 0;
    if (c[31:28] == 4'd0) begin
      if (y0 <= 23) mm[y0][x0] = c[17:10];
    end else if (c[31:28] == 4'd1) begin
      x1 = int'(c[17:13]); y1 = int'(c[12:8]);
      if (x1 > 31) x1 = 31;
      if (y1 > 23) y1 = 23;
      if (x0 <= x1 && y0 <= y1 && y0 <= 23) begin
        for (int y = y0; y <= y1; y++)
          for (int x = x0; x <= x1; x++) begin
            if (limit < 0 || n < limit) mm[y][x] = c[7:0];
            n++;
          end
      end
    end
  endtask

  // One clock cycle: optionally push a command, check busy/ovf for this cycle.
  task automatic tick(input bit vld, input logic [31:0] c, input bit apply, output bit acc);
    bit exp_busy, exp_ovf;
    int p;
    cmd_vld = vld;
    cmd     = c;
    exp_busy = (cyc < last_free);
    exp_ovf  = drop_seen;
    while (pend_pop.size() > 0 && pend_pop[0] < cyc) void'(pend_pop.pop_front());
    acc = 1'b0;
    if (vld) begin
      if (pend_pop.size() >= 4) begin
        drop_seen = 1'b1;
      end else begin
        acc = 1'b1;
        p = (cyc + 1 > last_free) ? cyc + 1 : last_free;
        pend_pop.push_back(p);
        last_free = p + cmd_dur(c);
        if (apply) model_apply(c, -1);
      end
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(exp_busy));
    check("ovf", 32'(ovf), 32'(exp_ovf));
    last_busy = busy;
    @(posedge clk);
    #1;
    cyc++;
    cmd_vld = 1'b0;
  endtask

  task automatic idle_tick();
    tick(1'b0, 32'd0, 1'b0, acc_dummy);
  endtask

  task automatic push(input logic [31:0] c);
    tick(1'b1, c, 1'b1, acc_dummy);
  endtask

  task automatic read_check(input string tag, input int x, input int y, input logic [7:0] exp);
    rd_x = 5'(x);
    rd_y = 5'(y);
    idle_tick();
    check(tag, 32'(rd_color), 32'(exp));
  endtask

  task automatic check_all(input string tag);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 32; x++)
        read_check(tag, x, y, mm[y][x]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || cyc < last_free) && n < 5000) begin
      idle_tick();
      n++;
    end
    check("idle_bound", 32'(n < 5000), 32'd1);
  endtask

  // Count busy-high cycles following a push, bounded.
  task automatic count_busy(output int n);
    int g;
    n = 0;
    g = 0;
    do begin
      idle_tick();
      if (last_busy) n++;
      g++;
    end while (last_busy && g < 3000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    pend_pop.delete();
    last_free = 0;
    drop_seen = 1'b0;
  endtask

  function automatic logic [31:0] rand_cmd();
    int r;
    logic [4:0] x0, y0, x1, y1;
    r  = $urandom_range(0, 99);
    x0 = 5'($urandom_range(0, 31));
    y0 = 5'($urandom_range(0, 31));
    if (r < 45) return mk_point(x0, y0, 8'($urandom));
    if (r < 85) begin
      y0 = 5'($urandom_range(0, 26));
      x1 = x0 + 5'($urandom_range(0, 4)) - 5'd1;
      y1 = y0 + 5'($urandom_range(0, 4)) - 5'd1;
      return mk_rect(x0, y0, x1, y1, 8'($urandom));
    end
    return {4'($urandom_range(2, 15)), 28'($urandom)};
  endfunction

  int n_busy;
  logic [31:0] big;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_color", 32'(rd_color), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Clear screen then a single point
    push(mk_rect(5'd0, 5'd0, 5'd31, 5'd23, 8'h00));
    push(mk_point(5'd3, 5'd5, 8'h0f));
    wait_idle();
    read_check("pt_3_5", 3, 5, 8'h0f);
    read_check("pt_4_5", 4, 5, 8'h00);
    check("ovf_first", 32'(ovf), 32'd0);
    check_all("tile_init");

    // Full-screen fill keeps busy for 770 cycles
    push(mk_rect(5'd0, 5'd0, 5'd31, 5'd23, 8'hff));
    count_busy(n_busy);
    check("busy_fullscreen", 32'(n_busy), 32'd770);
    check_all("tile_ff");

    // Point write latency and read-during-write
    push(mk_point(5'd7, 5'd2, 8'h3c));
    idle_tick();
    read_check("rd_old", 7, 2, 8'hff);
    read_check("rd_new", 7, 2, 8'h3c);

    // Back-to-back pushes
    push(mk_point(5'd1, 5'd1, 8'h0f));
    push(mk_point(5'd2, 5'd1, 8'hff));
    push(mk_point(5'd3, 5'd1, 8'he0));
    push(mk_rect(5'd0, 5'd0, 5'd1, 5'd0, 8'h11));
    wait_idle();
    read_check("b2b_1_1", 1, 1, 8'h0f);
    read_check("b2b_2_1", 2, 1, 8'hff);
    read_check("b2b_3_1", 3, 1, 8'he0);
    read_check("b2b_0_0", 0, 0, 8'h11);
    read_check("b2b_1_0", 1, 0, 8'h11);
    read_check("b2b_2_0", 2, 0, 8'hff);
    check("ovf_b2b", 32'(ovf), 32'd0);

    // Boundaries
    push(mk_rect(5'd10, 5'd0, 5'd5, 5'd3, 8'h55));
    count_busy(n_busy);
    check("empty_rect_cycles", 32'(n_busy), 32'd2);
    push(mk_point(5'd4, 5'd30, 8'h77));
    count_busy(n_busy);
    check("bad_point_cycles", 32'(n_busy), 32'd2);
    push(mk_rect(5'd0, 5'd20, 5'd0, 5'd30, 8'h66));
    wait_idle();
    push(32'hf000_0000 | 32'($urandom_range(0, 32'h0fff_ffff)));
    wait_idle();
    read_check("clip_0_19", 0, 19, 8'hff);
    read_check("clip_0_23", 0, 23, 8'h66);
    read_check("empty_10_0", 10, 0, 8'hff);
    check_all("tile_bound");

    // Overflow: a long fill followed by six points on consecutive cycles
    push(mk_rect(5'd0, 5'd0, 5'd31, 5'd23, 8'h22));
    for (int i = 0; i < 6; i++) push(mk_point(5'(4 + i), 5'd10, 8'(8'h40 + i)));
    wait_idle();
    check("ovf_sticky", 32'(ovf), 32'd1);
    read_check("kept_pt1", 4, 10, 8'h40);
    read_check("kept_pt4", 7, 10, 8'h43);
    read_check("drop_pt5", 8, 10, 8'h22);
    read_check("drop_pt6", 9, 10, 8'h22);
    check_all("tile_ovf");

    // Reset in the middle of a full-screen fill: 298 tiles are written first
    big = mk_rect(5'd0, 5'd0, 5'd31, 5'd23, 8'h99);
    tick(1'b1, big, 1'b0, acc_dummy);
    repeat (300) idle_tick();
    do_reset();
    model_apply(big, 298);
    push(mk_point(5'd20, 5'd15, 8'h42));
    wait_idle();
    check_all("tile_rst");

    // Random command streams, including overflow
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 25) push(rand_cmd());
      else idle_tick();
    end
    wait_idle();
    check_all("tile_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
